// File: rtl/viterbi_if.sv
// viterbi_if: symbol, mask-load and decision signals of viterbi_dec.
// The master drives symbols and masks; the decoder returns decisions.
interface viterbi_if #(
  parameter int N = 6
);
  logic [1:0]   load_mask;
  logic [N-1:0] mask;
  logic         in_valid;
  logic [1:0]   in_sym;
  logic         out_valid;
  logic         out_bit;

  modport master (
    output load_mask, mask, in_valid, in_sym,
    input  out_valid, out_bit
  );

  modport slave (
    input  load_mask, mask, in_valid, in_sym,
    output out_valid, out_bit
  );
endinterface

// File: rtl/viterbi_dec.sv
// viterbi_dec: hard-decision rate-1/2 Viterbi decoder, register-exchange
// survivors, programmable generator masks shared with conv_enc.
module viterbi_dec #(
  parameter int N        = 6,
  parameter int TB_DEPTH = 30,
  parameter int METRIC_W = 8
) (
  input logic      clk,
  input logic      reset,
  viterbi_if.slave bus
);

  localparam int NS = 1 << (N - 1);
  localparam int SW = N - 1;
  localparam int CW = $clog2(TB_DEPTH + 1);

  localparam logic [METRIC_W-1:0] M_INIT =
    {2'b01, {(METRIC_W-2){1'b0}}};
  localparam logic [METRIC_W-1:0] M_MSB =
    {1'b1, {(METRIC_W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = CW'(TB_DEPTH);
  localparam logic [CW-1:0] CNT_DEC = CW'(TB_DEPTH - 1);

  logic [N-1:0]          mask0;
  logic [N-1:0]          mask1;
  logic [METRIC_W-1:0]   metric [NS];
  logic [TB_DEPTH-1:0]   path   [NS];
  logic [CW-1:0]         cnt;

  logic [METRIC_W:0]     raw    [NS];
  logic                  sel    [NS];
  logic [METRIC_W-1:0]   nmet   [NS];
  logic [TB_DEPTH-1:0]   npath  [NS];
  logic                  all_hi;
  logic [METRIC_W-1:0]   clr;
  logic [SW-1:0]         best;
  logic [METRIC_W-1:0]   bmin;
  logic [CW-1:0]         cnt_nx;

  // Hamming distance between the received symbol and the
  // encoder output for register contents r.
  function automatic logic [1:0] bm_f(
    input logic [N-1:0] r,
    input logic [1:0]   sym,
    input logic [N-1:0] g0,
    input logic [N-1:0] g1
  );
    logic [1:0] x;
    x = sym ^ {^(r & g1), ^(r & g0)};
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

  // One add-compare-select cell per destination state T.
  // Predecessors are {T[N-3:0], b}; the decoded bit is T[N-2].
  for (genvar t = 0; t < NS; t++) begin : g_acs
    localparam logic [SW-1:0] TV = SW'(t);
    localparam logic [SW-1:0] S0 = {TV[SW-2:0], 1'b0};
    localparam logic [SW-1:0] S1 = {TV[SW-2:0], 1'b1};

    logic [1:0]        bm0;
    logic [1:0]        bm1;
    logic [METRIC_W:0] c0;
    logic [METRIC_W:0] c1;

    assign bm0 = bm_f({TV[SW-1], S0}, bus.in_sym, mask0, mask1);
    assign bm1 = bm_f({TV[SW-1], S1}, bus.in_sym, mask0, mask1);
    assign c0  = {1'b0, metric[S0]} + (METRIC_W+1)'(bm0);
    assign c1  = {1'b0, metric[S1]} + (METRIC_W+1)'(bm1);

    // ties go to the b = 0 predecessor
    assign sel[t] = (c1 < c0);
    assign raw[t] = sel[t] ? c1 : c0;

    assign npath[t] = {
      (sel[t] ? path[S1][TB_DEPTH-2:0] : path[S0][TB_DEPTH-2:0]),
      TV[SW-1]
    };

    // bit METRIC_W cannot be reached while the spread stays
    // bounded; saturating keeps the metric monotone regardless
    assign nmet[t] = raw[t][METRIC_W] ? '1
                   : (raw[t][METRIC_W-1:0] & ~clr);
  end

  // Normalise by dropping the MSB once every new metric has it set.
  always_comb begin
    all_hi = 1'b1;
    for (int t = 0; t < NS; t++) begin
      all_hi = all_hi & raw[t][METRIC_W-1];
    end
    clr = all_hi ? M_MSB : '0;
  end

  // Best state: smallest new metric, lowest index on a tie.
  always_comb begin
    best = '0;
    bmin = nmet[0];
    for (int t = 1; t < NS; t++) begin
      if (nmet[t] < bmin) begin
        bmin = nmet[t];
        best = SW'(t);
      end
    end
  end

  // Saturating count of accepted symbols since restart.
  always_comb begin
    cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  // Masks, trellis state and the registered decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask0         <= '0;
      mask1         <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_bit   <= 1'b0;
      for (int t = 0; t < NS; t++) begin
        metric[t] <= (t == 0) ? '0 : M_INIT;
        path[t]   <= '0;
      end
    end else if (bus.load_mask != 2'b00) begin
      if (bus.load_mask[0]) mask0 <= bus.mask;
      if (bus.load_mask[1]) mask1 <= bus.mask;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      for (int t = 0; t < NS; t++) begin
        metric[t] <= (t == 0) ? '0 : M_INIT;
        path[t]   <= '0;
      end
    end else if (bus.in_valid) begin
      cnt           <= cnt_nx;
      bus.out_valid <= (cnt >= CNT_DEC);
      bus.out_bit   <= npath[best][TB_DEPTH-1];
      for (int t = 0; t < NS; t++) begin
        metric[t] <= nmet[t];
        path[t]   <= npath[t];
      end
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
